// File: rtl/bfm_stim_streamer_if.sv
// Beat load, BFM beat and BFM result channels of the stimulus streamer.
// Latency: none, this is wiring only.
// Backpressure: wr and out channels are valid/ready; the result channel has no ready.
// Ports: wr_* load beats from the bench, out_* beats to the BFM, res_* results back from the BFM.
// master = bench/BFM side, slave = streamer side.
interface bfm_stim_streamer_if #(
  parameter int DATA_W = 8,
  parameter int LANES  = 2
);
  logic                    wr_valid_i;
  logic                    wr_ready_o;
  logic [LANES*DATA_W-1:0] wr_data_i;
  logic                    out_valid_o;
  logic                    out_ready_i;
  logic [LANES*DATA_W-1:0] out_data_o;
  logic                    res_valid_i;
  logic [DATA_W-1:0]       res_data_i;

  modport master (
    output wr_valid_i, wr_data_i, out_ready_i, res_valid_i, res_data_i,
    input  wr_ready_o, out_valid_o, out_data_o
  );

  modport slave (
    input  wr_valid_i, wr_data_i, out_ready_i, res_valid_i, res_data_i,
    output wr_ready_o, out_valid_o, out_data_o
  );
endinterface

// File: rtl/bfm_stim_streamer.sv
// Stimulus engine: buffers LANES-wide operand beats and streams a programmed count to the BFM.
// Latency: a loaded beat is visible on out_data_o the cycle after it is written.
// Backpressure: wr_ready_o drops when the buffer is full; out_ready_i low stalls the head beat.
// Ports: clk_i/reset_i (async, active-low), bus (slave modport: wr/out/res channels),
//   start_i/length_i start a run, busy_o/done_o/err_o status, sent/recv counters and result sum.
// Build option: define STIM_LOOP_EN to turn the buffer into a non-consuming replay memory.
module bfm_stim_streamer #(
  parameter int DATA_W  = 8,
  parameter int LANES   = 2,
  parameter int DEPTH   = 16,
  parameter int CNT_W   = 32,
  parameter int TIMEOUT = 1024
) (
  input  logic               clk_i,
  input  logic               reset_i,
  bfm_stim_streamer_if.slave bus,
  input  logic               start_i,
  input  logic [CNT_W-1:0]   length_i,
  output logic               busy_o,
  output logic               done_o,
  output logic               err_o,
  output logic [CNT_W-1:0]   sent_cnt_o,
  output logic [CNT_W-1:0]   recv_cnt_o,
  output logic [CNT_W-1:0]   res_sum_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int BW = LANES * DATA_W;

  typedef enum logic [1:0] {IDLE, STREAM, DRAIN, DONE} state_t;

  state_t           state, state_nxt;
  logic [BW-1:0]    mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW-1:0]    rd_addr;
  logic             rst_done, full, empty, push, pop;
  logic             run_start, last_pop, timeout_hit;
  logic [CNT_W-1:0] len_q, idle_cnt;

  // Holds wr_ready_o low while in reset and releases it on the first edge afterwards.
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) rst_done <= 1'b0;
    else          rst_done <= 1'b1;
  end

  assign run_start = start_i && ((state == IDLE) || (state == DONE));
  assign push      = bus.wr_valid_i && bus.wr_ready_o;
  assign pop       = bus.out_valid_o && bus.out_ready_i;
  assign last_pop  = pop && ((sent_cnt_o + CNT_W'(1)) == len_q);
  assign timeout_hit = (state == DRAIN) && (recv_cnt_o != sent_cnt_o) && !bus.res_valid_i &&
                       (idle_cnt == CNT_W'(TIMEOUT - 1));

`ifdef STIM_LOOP_EN
  // Replay memory: wr_ptr counts loaded entries, the head index wraps after the last one.
  logic [AW-1:0] rd_idx;

  assign rd_addr        = rd_idx;
  assign full           = wr_ptr[AW];
  assign empty          = (wr_ptr == '0);
  assign bus.wr_ready_o = rst_done && !full && !busy_o;

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      wr_ptr <= '0;
      rd_idx <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (run_start)
        rd_idx <= '0;
      else if (pop)
        rd_idx <= (({1'b0, rd_idx} + (AW+1)'(1)) == wr_ptr) ? '0 : rd_idx + AW'(1);
    end
  end
`else
  // Consuming FIFO; the extra pointer bit separates full from empty.
  logic [AW:0] rd_ptr;

  assign rd_addr        = rd_ptr[AW-1:0];
  assign full           = ((wr_ptr ^ rd_ptr) == {1'b1, {AW{1'b0}}});
  assign empty          = (wr_ptr == rd_ptr);
  assign bus.wr_ready_o = rst_done && !full;

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end
`endif

  always_ff @(posedge clk_i) begin
    if (push) mem[wr_ptr[AW-1:0]] <= bus.wr_data_i;
  end

  // State register
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) state <= IDLE;
    else          state <= state_nxt;
  end

  // Next-state logic; leaving STREAM on the final pop keeps out_valid_o low afterwards.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, DONE: if (start_i) state_nxt = (length_i != '0) ? STREAM : DONE;
      STREAM:     if (last_pop) state_nxt = DRAIN;
      DRAIN:      if ((recv_cnt_o == sent_cnt_o) || timeout_hit) state_nxt = DONE;
      default:    state_nxt = IDLE;
    endcase
  end

  // Outputs; head data is read straight from the buffer and forced to zero when empty.
  always_comb begin
    bus.out_valid_o = 1'b0;
    busy_o          = 1'b0;
    done_o          = 1'b0;
    case (state)
      STREAM: begin
        busy_o          = 1'b1;
        bus.out_valid_o = !empty;
      end
      DRAIN:   busy_o = 1'b1;
      DONE:    done_o = 1'b1;
      default: ;
    endcase
    bus.out_data_o = empty ? '0 : mem[rd_addr];
  end

  // Run counters, result sum, drain idle timer and sticky error.
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      sent_cnt_o <= '0;
      recv_cnt_o <= '0;
      res_sum_o  <= '0;
      idle_cnt   <= '0;
      len_q      <= '0;
      err_o      <= 1'b0;
    end else if (run_start) begin
      sent_cnt_o <= '0;
      recv_cnt_o <= '0;
      res_sum_o  <= '0;
      idle_cnt   <= '0;
      len_q      <= length_i;
      err_o      <= 1'b0;
    end else begin
      if (pop) sent_cnt_o <= sent_cnt_o + CNT_W'(1);
      if (bus.res_valid_i && (state != IDLE)) begin
        recv_cnt_o <= recv_cnt_o + CNT_W'(1);
        res_sum_o  <= res_sum_o + CNT_W'(bus.res_data_i);
      end
      // Counts only quiet DRAIN cycles; any result restarts the window.
      idle_cnt <= ((state == DRAIN) && !bus.res_valid_i) ? idle_cnt + CNT_W'(1) : '0;
      if (timeout_hit) err_o <= 1'b1;
    end
  end
endmodule
